// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word, RAM handshake state, and the
// arbiter's two-state FSM encoding plus a round-robin pointer helper.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Index that follows idx when counting modulo n (n need not be a power of 2).
  function automatic int rr_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  // A beat that finished with ACCESS or ERROR retires the current request.
  function automatic logic beat_ends(input ramstate_t rs);
    return (rs == ACCESS) || (rs == ERROR);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first pending index found
// when scanning from i_rr_ptr upward, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_pend,
  input  logic [IW-1:0]   i_rr_ptr,
  output logic            o_any,
  output logic [IW-1:0]   o_winner
);

  int w_idx;

  // Scan from farthest to nearest so the index closest to the pointer wins.
  always_comb begin
    o_any    = |i_pend;
    o_winner = '0;
    w_idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(i_rr_ptr) + k) % NREQ;
      if (i_pend[w_idx]) begin
        o_winner = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters. A grant
// may be held across locked bursts, capped at MAX_BEATS beats, and ERROR
// always ends the grant. Handshakes back to requesters are combinational.
module ram_port_arbiter
  import cpu_types_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int MAX_BEATS = 4
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NREQ-1:0]           req_ren,
  input  logic [NREQ-1:0]           req_wen,
  input  logic [NREQ-1:0]           req_lock,
  input  word_t [NREQ-1:0]          req_addr,
  input  word_t [NREQ-1:0]          req_store,
  output logic [NREQ-1:0]           req_wait,
  output word_t                     req_load,
  output logic [NREQ-1:0]           req_err,
  output logic                      gnt_valid,
  output logic [$clog2(NREQ)-1:0]   gnt_idx,
  output logic                      ramREN,
  output logic                      ramWEN,
  output word_t                     ramaddr,
  output word_t                     ramstore,
  input  word_t                     ramload,
  input  ramstate_t                 ramstate
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  arb_state_t      r_state,    w_next_state;
  logic [IW-1:0]   r_gnt_idx,  w_next_gnt;
  logic [IW-1:0]   r_rr_ptr,   w_next_rr;
  logic [BW-1:0]   r_beat_cnt, w_next_beat;

  logic [NREQ-1:0] w_pend;
  logic            w_any;
  logic [IW-1:0]   w_winner;
  logic            w_gnt_pend;
  logic            w_beat_end;
  logic            w_beat_err;
  logic            w_can_extend;
  logic [IW-1:0]   w_rr_after;

  assign w_pend       = req_ren | req_wen;
  assign w_gnt_pend   = w_pend[r_gnt_idx];
  assign w_beat_end   = (r_state == XFER) && w_gnt_pend && beat_ends(ramstate);
  assign w_beat_err   = w_beat_end && (ramstate == ERROR);
  assign w_can_extend = req_lock[r_gnt_idx] && !w_beat_err
                        && (int'(r_beat_cnt) < MAX_BEATS - 1);
  assign w_rr_after   = IW'(rr_next(int'(r_gnt_idx), NREQ));

  assign req_load  = ramload;
  assign gnt_valid = (r_state == XFER);
  assign gnt_idx   = r_gnt_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_pend   (w_pend),
    .i_rr_ptr (r_rr_ptr),
    .o_any    (w_any),
    .o_winner (w_winner)
  );

  // FSM and arbitration registers; reset drops straight back to IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_gnt_idx  <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_gnt_idx  <= w_next_gnt;
      r_rr_ptr   <= w_next_rr;
      r_beat_cnt <= w_next_beat;
    end
  end

  // Next-state: grant in IDLE, then extend, release or abort in XFER.
  always_comb begin
    w_next_state = r_state;
    w_next_gnt   = r_gnt_idx;
    w_next_rr    = r_rr_ptr;
    w_next_beat  = r_beat_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_state = XFER;
          w_next_gnt   = w_winner;
          w_next_beat  = '0;
        end
      end
      XFER: begin
        if (!w_gnt_pend) begin
          w_next_state = IDLE;
          w_next_rr    = w_rr_after;
          w_next_beat  = '0;
        end else if (w_beat_end) begin
          if (w_can_extend) begin
            w_next_beat = r_beat_cnt + BW'(1);
          end else begin
            w_next_state = IDLE;
            w_next_rr    = w_rr_after;
            w_next_beat  = '0;
          end
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // RAM-side drive: only the granted requester reaches the port, write wins.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (r_state == XFER) begin
      ramaddr = req_addr[r_gnt_idx];
      if (req_wen[r_gnt_idx]) begin
        ramWEN   = 1'b1;
        ramstore = req_store[r_gnt_idx];
      end else begin
        ramREN = req_ren[r_gnt_idx];
      end
    end
  end

  // Requester handshake: wait until own beat completes, error pulse on ERROR.
  always_comb begin
    req_wait = '0;
    req_err  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_wait[i] = w_pend[i] & ~(w_beat_end & (int'(r_gnt_idx) == i));
      req_err[i]  = w_beat_err & (int'(r_gnt_idx) == i);
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (NREQ=4, MAX_BEATS=4)
// plus a small standalone check of rr_pick with a 3-entry ring.
module tb_ram_port_arbiter;
  import cpu_types_pkg::*;

  localparam int NREQ      = 4;
  localparam int MAX_BEATS = 4;

  logic              CLK;
  logic              nRST;
  logic [NREQ-1:0]   req_ren;
  logic [NREQ-1:0]   req_wen;
  logic [NREQ-1:0]   req_lock;
  word_t [NREQ-1:0]  req_addr;
  word_t [NREQ-1:0]  req_store;
  logic [NREQ-1:0]   req_wait;
  word_t             req_load;
  logic [NREQ-1:0]   req_err;
  logic              gnt_valid;
  logic [1:0]        gnt_idx;
  logic              ramREN;
  logic              ramWEN;
  word_t             ramaddr;
  word_t             ramstore;
  word_t             ramload;
  ramstate_t         ramstate;

  logic [2:0]        pickPend;
  logic [1:0]        pickPtr;
  logic              pickAny;
  logic [1:0]        pickWinner;

  int checkCount;
  int failCount;

  ram_port_arbiter #(
    .NREQ      (NREQ),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_store (req_store),
    .req_wait  (req_wait),
    .req_load  (req_load),
    .req_err   (req_err),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate)
  );

  rr_pick #(
    .NREQ (3)
  ) u_pick (
    .i_pend   (pickPend),
    .i_rr_ptr (pickPtr),
    .o_any    (pickAny),
    .o_winner (pickWinner)
  );

  // Free-running 100 MHz-style clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic applyStimulus(input logic [3:0] ren, input logic [3:0] wen,
                               input logic [3:0] lock, input ramstate_t rs);
    req_ren  = ren;
    req_wen  = wen;
    req_lock = lock;
    ramstate = rs;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sampleHalf();
    @(negedge CLK);
  endtask

  task automatic resetDut();
    nRST = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, FREE);
    nextCycle();
    nRST = 1'b1;
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    ramload    = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i]  = 32'h100 * i;
      req_store[i] = '0;
    end

    // rr_pick on a 3-entry ring, including wrap from the top index
    pickPend = 3'b001; pickPtr = 2'd2; #1;
    checkOutput("pick_wrap_winner", 32'(pickWinner), 32'd0);
    checkOutput("pick_wrap_any", 32'(pickAny), 32'd1);
    pickPend = 3'b110; pickPtr = 2'd0; #1;
    checkOutput("pick_from0", 32'(pickWinner), 32'd1);
    pickPend = 3'b101; pickPtr = 2'd1; #1;
    checkOutput("pick_from1", 32'(pickWinner), 32'd2);
    pickPend = 3'b000; pickPtr = 2'd1; #1;
    checkOutput("pick_none", 32'(pickAny), 32'd0);

    // Reset state
    nRST = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, FREE);
    sampleHalf();
    checkOutput("rst_gnt_valid", 32'(gnt_valid), 32'd0);
    checkOutput("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    checkOutput("rst_ramREN", 32'(ramREN), 32'd0);
    checkOutput("rst_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'd0);
    checkOutput("rst_err", 32'(req_err), 32'd0);
    req_ren = 4'b0010; #1;
    checkOutput("rst_wait_follows_pend", 32'(req_wait), 32'b0010);
    req_ren = 4'b0000;
    nextCycle();
    nRST = 1'b1;

    // Single read with two BUSY cycles before ACCESS
    applyStimulus(4'b0010, 4'b0000, 4'b0000, FREE);
    sampleHalf();
    checkOutput("rd_c0_gnt_valid", 32'(gnt_valid), 32'd0);
    checkOutput("rd_c0_ramREN", 32'(ramREN), 32'd0);
    checkOutput("rd_c0_wait", 32'(req_wait), 32'b0010);
    nextCycle();
    ramstate = BUSY;
    sampleHalf();
    checkOutput("rd_c1_gnt_valid", 32'(gnt_valid), 32'd1);
    checkOutput("rd_c1_gnt_idx", 32'(gnt_idx), 32'd1);
    checkOutput("rd_c1_ramREN", 32'(ramREN), 32'd1);
    checkOutput("rd_c1_ramaddr", ramaddr, 32'h100);
    checkOutput("rd_c1_wait", 32'(req_wait), 32'b0010);
    nextCycle();
    sampleHalf();
    checkOutput("rd_c2_ramREN", 32'(ramREN), 32'd1);
    checkOutput("rd_c2_wait", 32'(req_wait), 32'b0010);
    nextCycle();
    ramstate = ACCESS;
    ramload  = 32'hDEADBEEF;
    sampleHalf();
    checkOutput("rd_c3_ramREN", 32'(ramREN), 32'd1);
    checkOutput("rd_c3_ramaddr", ramaddr, 32'h100);
    checkOutput("rd_c3_wait", 32'(req_wait), 32'b0000);
    checkOutput("rd_c3_load", req_load, 32'hDEADBEEF);
    checkOutput("rd_c3_err", 32'(req_err), 32'd0);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, FREE);
    sampleHalf();
    checkOutput("rd_c4_idle", 32'(gnt_valid), 32'd0);
    checkOutput("rd_c4_ramREN", 32'(ramREN), 32'd0);
    checkOutput("rd_c4_gnt_hold", 32'(gnt_idx), 32'd1);

    // Fairness: all four hold unlocked reads with instant ACCESS
    resetDut();
    applyStimulus(4'b1111, 4'b0000, 4'b0000, ACCESS);
    for (int k = 0; k < 6; k++) begin
      sampleHalf();
      checkOutput($sformatf("rr_idle_%0d", k), 32'(gnt_valid), 32'd0);
      nextCycle();
      sampleHalf();
      checkOutput($sformatf("rr_valid_%0d", k), 32'(gnt_valid), 32'd1);
      checkOutput($sformatf("rr_idx_%0d", k), 32'(gnt_idx), 32'(k % 4));
      checkOutput($sformatf("rr_addr_%0d", k), ramaddr, 32'h100 * (k % 4));
      checkOutput($sformatf("rr_wait_%0d", k), 32'(req_wait),
                  32'(4'b1111 & ~(4'b0001 << (k % 4))));
      nextCycle();
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, FREE);

    // Locked two-beat write burst from req 2 while req 0 waits (rr_ptr=2)
    req_addr[2]  = 32'h200;
    req_store[2] = 32'h11;
    applyStimulus(4'b0001, 4'b0100, 4'b0100, FREE);
    sampleHalf();
    checkOutput("lk_idle_wait", 32'(req_wait), 32'b0101);
    nextCycle();
    ramstate = ACCESS;
    sampleHalf();
    checkOutput("lk_b0_idx", 32'(gnt_idx), 32'd2);
    checkOutput("lk_b0_ramWEN", 32'(ramWEN), 32'd1);
    checkOutput("lk_b0_ramREN", 32'(ramREN), 32'd0);
    checkOutput("lk_b0_addr", ramaddr, 32'h200);
    checkOutput("lk_b0_store", ramstore, 32'h11);
    checkOutput("lk_b0_wait", 32'(req_wait), 32'b0001);
    nextCycle();
    req_addr[2]  = 32'h204;
    req_store[2] = 32'h22;
    req_lock     = 4'b0000;
    sampleHalf();
    checkOutput("lk_b1_valid", 32'(gnt_valid), 32'd1);
    checkOutput("lk_b1_idx", 32'(gnt_idx), 32'd2);
    checkOutput("lk_b1_addr", ramaddr, 32'h204);
    checkOutput("lk_b1_store", ramstore, 32'h22);
    nextCycle();
    applyStimulus(4'b0001, 4'b0000, 4'b0000, FREE);
    sampleHalf();
    checkOutput("lk_after_idle", 32'(gnt_valid), 32'd0);
    nextCycle();
    ramstate = ACCESS;
    sampleHalf();
    checkOutput("lk_next_idx", 32'(gnt_idx), 32'd0);
    checkOutput("lk_next_ramREN", 32'(ramREN), 32'd1);
    checkOutput("lk_next_addr", ramaddr, 32'h0);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 4'b0000, FREE);
    req_addr[2]  = 32'h200;
    req_store[2] = '0;

    // Beat cap: req 0 locks forever with req 1 pending
    resetDut();
    applyStimulus(4'b0011, 4'b0000, 4'b0001, ACCESS);
    sampleHalf();
    checkOutput("cap_idle", 32'(gnt_valid), 32'd0);
    nextCycle();
    for (int b = 0; b < MAX_BEATS; b++) begin
      sampleHalf();
      checkOutput($sformatf("cap_beat%0d_valid", b), 32'(gnt_valid), 32'd1);
      checkOutput($sformatf("cap_beat%0d_idx", b), 32'(gnt_idx), 32'd0);
      checkOutput($sformatf("cap_beat%0d_wait", b), 32'(req_wait), 32'b0010);
      nextCycle();
    end
    sampleHalf();
    checkOutput("cap_release", 32'(gnt_valid), 32'd0);
    nextCycle();
    sampleHalf();
    checkOutput("cap_other_idx", 32'(gnt_idx), 32'd1);
    checkOutput("cap_other_wait", 32'(req_wait), 32'b0001);
    nextCycle();
    sampleHalf();
    checkOutput("cap_idle2", 32'(gnt_valid), 32'd0);
    nextCycle();
    sampleHalf();
    checkOutput("cap_regain_idx", 32'(gnt_idx), 32'd0);
    checkOutput("cap_regain_valid", 32'(gnt_valid), 32'd1);
    nextCycle();

    // Abort: req 0 drops its read while still granted mid-burst
    applyStimulus(4'b0000, 4'b0000, 4'b0000, ACCESS);
    sampleHalf();
    checkOutput("abort_ramREN", 32'(ramREN), 32'd0);
    checkOutput("abort_err", 32'(req_err), 32'd0);
    checkOutput("abort_wait", 32'(req_wait), 32'd0);
    nextCycle();
    sampleHalf();
    checkOutput("abort_idle", 32'(gnt_valid), 32'd0);
    checkOutput("abort_err_after", 32'(req_err), 32'd0);

    // ERROR on a locked read ends the grant with a one-cycle err pulse
    nextCycle();
    applyStimulus(4'b0010, 4'b0000, 4'b0010, FREE);
    nextCycle();
    ramstate = BUSY;
    sampleHalf();
    checkOutput("err_busy_idx", 32'(gnt_idx), 32'd1);
    checkOutput("err_busy_err", 32'(req_err), 32'd0);
    checkOutput("err_busy_wait", 32'(req_wait), 32'b0010);
    nextCycle();
    ramstate = ERROR;
    sampleHalf();
    checkOutput("err_pulse", 32'(req_err), 32'b0010);
    checkOutput("err_wait", 32'(req_wait), 32'b0000);
    nextCycle();
    ramstate = FREE;
    sampleHalf();
    checkOutput("err_released", 32'(gnt_valid), 32'd0);
    checkOutput("err_pulse_over", 32'(req_err), 32'd0);
    req_ren  = 4'b0000;
    req_lock = 4'b0000;

    // Reset asserted mid-write drops ramWEN immediately
    nextCycle();
    req_store[3] = 32'hCAFE;
    applyStimulus(4'b0000, 4'b1000, 4'b0000, BUSY);
    nextCycle();
    sampleHalf();
    checkOutput("rstx_ramWEN_before", 32'(ramWEN), 32'd1);
    checkOutput("rstx_addr_before", ramaddr, 32'h300);
    checkOutput("rstx_store_before", ramstore, 32'hCAFE);
    nRST = 1'b0;
    #1;
    checkOutput("rstx_ramWEN", 32'(ramWEN), 32'd0);
    checkOutput("rstx_gnt_valid", 32'(gnt_valid), 32'd0);
    checkOutput("rstx_err", 32'(req_err), 32'd0);
    checkOutput("rstx_wait", 32'(req_wait), 32'b1000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, FREE);
    nextCycle();
    nRST = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
